// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction fetch / data) arbiter in front of a
// single-ported memory. Three-state FSM (IDLE, FETCH, DATA); the granted
// request is latched and drives the memory port until mem_ready.
// Optional macro ARB_STARVE_GUARD_EN adds a saturating counter that lets a
// waiting fetch win after STARVE_LIMIT consecutive data grants.
module mem_arbiter #(
  parameter int WIDTH        = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_addr,
  output logic [WIDTH-1:0] i_rdata,
  output logic             i_ack,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic             stall_fetch
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             we_q, we_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic             fetch_wins;
  logic             grant_data;
  logic             grant_fetch;

  // Grant decisions are only made in IDLE; data has priority unless the
  // starvation guard says the waiting fetch has been passed over too often.
  assign grant_data  = (state_q == IDLE) && d_req && !(i_req && fetch_wins);
  assign grant_fetch = (state_q == IDLE) && i_req && !grant_data;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_q, starve_d;

  assign fetch_wins = (starve_q == CW'(STARVE_LIMIT));

  // Count data grants that bypassed a waiting fetch; saturate; clear on fetch grant.
  always_comb begin
    starve_d = starve_q;
    if (grant_fetch) begin
      starve_d = '0;
    end else if (grant_data && i_req && (starve_q != CW'(STARVE_LIMIT))) begin
      starve_d = starve_q + CW'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  assign fetch_wins = 1'b0;
`endif

  // Next state and latched transaction; the latch only happens on a grant, so
  // requests arriving while busy cannot disturb the transaction in flight.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    unique case (state_q)
      IDLE: begin
        if (grant_data) begin
          state_d = DATA;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          we_d    = d_we;
        end else if (grant_fetch) begin
          state_d = FETCH;
          addr_d  = i_addr;
          we_d    = 1'b0;
        end
      end
      FETCH, DATA: begin
        if (mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    mem_req_d = (state_d != IDLE);
    mem_we_d  = (state_d == DATA) && we_d;
  end

  // FSM state, latched request and registered memory strobes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Completion is same-cycle with mem_ready; read data passes straight through.
  assign i_ack       = (state_q == FETCH) && mem_ready;
  assign d_ack       = (state_q == DATA)  && mem_ready;
  assign i_rdata     = mem_rdata;
  assign d_rdata     = mem_rdata;
  assign stall_fetch = i_req && !i_ack;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: address and data width.
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive data grants after which a waiting fetch wins (used only when ARB_STARVE_GUARD_EN is defined).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; the ports are clock and reset.
REQ-004 clock  in  1  system clock, rising-edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 i_req  in  1  instruction-fetch read request; held with i_addr stable until i_ack.
REQ-007 i_addr  in  WIDTH  fetch address.
REQ-008 i_rdata  out  WIDTH  fetch read data; valid only while i_ack is high.
REQ-009 i_ack  out  1  one-cycle fetch completion pulse.
REQ-010 d_req  in  1  data request; held with d_we, d_addr and d_wdata stable until d_ack.
REQ-011 d_we  in  1  1 = store, 0 = load.
REQ-012 d_addr  in  WIDTH  data address.
REQ-013 d_wdata  in  WIDTH  store data.
REQ-014 d_rdata  out  WIDTH  load data; valid only while d_ack is high.
REQ-015 d_ack  out  1  one-cycle data completion pulse.
REQ-016 mem_req  out  1  memory transaction active.
REQ-017 mem_we  out  1  memory write strobe.
REQ-018 mem_addr  out  WIDTH  memory address.
REQ-019 mem_wdata  out  WIDTH  memory write data.
REQ-020 mem_rdata  in  WIDTH  memory read data; valid with mem_ready.
REQ-021 mem_ready  in  1  memory completes the current transaction this cycle.
REQ-022 stall_fetch  out  1  i_req & ~i_ack; drives the pipeline fetch stall.

Function
REQ-023 The FSM SHALL have exactly three states: IDLE, FETCH and DATA.
REQ-024 In IDLE with d_req=1, the next state SHALL be DATA; with only i_req=1, it SHALL be FETCH; with no request, it SHALL stay in IDLE.
REQ-025 On a grant, the arbiter SHALL latch the granted address, write data and we into registers; mem_addr, mem_wdata and mem_we SHALL come only from these registers.
REQ-026 mem_req SHALL be 1 in FETCH and DATA, and 0 in IDLE.
REQ-027 mem_we SHALL be 0 in FETCH, 0 in IDLE, and equal to the latched d_we in DATA.
REQ-028 In FETCH or DATA with mem_ready=1, the matching ack SHALL be high in that same cycle, and the matching rdata SHALL equal mem_rdata combinationally.
REQ-029 In that same cycle, the FSM SHALL return to IDLE; there is exactly one IDLE cycle between transactions.
REQ-030 The minimum latency is 2 cycles from request to ack (grant cycle plus one memory cycle with mem_ready=1).
REQ-031 mem_ready asserted in IDLE SHALL be ignored.
REQ-032 The ack of the non-granted requester SHALL never be asserted.
REQ-033 A request arriving while busy SHALL wait and SHALL not disturb the latched transaction.
REQ-034 Simultaneous i_req and d_req in IDLE SHALL grant data, subject to REQ-041.

Reset
REQ-035 While reset=0, the state SHALL be IDLE and all registers SHALL be 0 (so mem_req, mem_we, i_ack, d_ack and mem_addr are 0).
REQ-036 A reset mid-transaction SHALL abandon it: no ack, and mem_req low immediately.
REQ-037 On reset release, arbitration SHALL restart from IDLE, and the starvation counter SHALL be 0.

Configuration
REQ-038 The macro ARB_STARVE_GUARD_EN SHALL select the starvation guard.
REQ-039 When the macro is defined, a counter SHALL increment on each data grant made while i_req=1, and SHALL clear on every fetch grant.
REQ-040 The counter SHALL saturate at STARVE_LIMIT.
REQ-041 With the macro defined and the counter at STARVE_LIMIT, IDLE with both requests SHALL grant FETCH.
REQ-042 When the macro is not defined, the counter SHALL not exist and data SHALL always have priority.

Verification
REQ-043 Lone fetch: i_req=1, i_addr=0x10, mem_ready=1 from cycle 1 with mem_rdata=0x00500093 -> mem_addr=0x10, mem_we=0, i_ack high in cycle 1, i_rdata=0x00500093.
REQ-044 Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, mem_ready delayed 3 cycles -> mem_req and mem_we held for 3 cycles, then d_ack for 1 cycle, no i_ack.
REQ-045 Simultaneous: i_req=d_req=1 in the same cycle -> DATA is granted first; after d_ack, one IDLE cycle, then FETCH, then i_ack; stall_fetch is high throughout.
REQ-046 Starvation, macro defined, STARVE_LIMIT=4: i_req held while d_req is reissued continuously -> fetch is granted after exactly 4 data grants. Macro undefined: fetch is never granted.
REQ-047 Reset mid-transaction: reset=0 during DATA before mem_ready -> mem_req=0 asynchronously, no d_ack; after release, a held d_req is regranted.
REQ-048 Spurious ready: mem_ready=1 in IDLE with no requests -> no ack and the state stays IDLE.
